// File: rtl/fetch_sequencer.sv
// PC and run-control stage: Req/Ack start/done handshake, stall/halt/branch next-PC selection.
// Optional cycle counter is built only when FETCH_CYCLE_CNT_EN is defined.
module fetch_sequencer #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Req,
    input  logic            Stall,
    input  logic            Halt,
    input  logic            Branch,
    input  logic            Take,
    input  logic [PC_W-1:0] Target,
    output logic [PC_W-1:0] Prog_Ctr,
    output logic            Run,
    output logic            Ack
`ifdef FETCH_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0] Cycle_Count
`endif
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e state;
    logic   req_q;
    logic   start;

    assign start = Req & ~req_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= StIdle;
            Prog_Ctr <= START_PC;
            Run      <= 1'b0;
            Ack      <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            req_q <= Req;
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state    <= StRun;
                        Prog_Ctr <= START_PC;
                        Run      <= 1'b1;
                        Ack      <= 1'b0;
                    end
                end
                StRun: begin
                    // Stall overrides everything, including Halt.
                    if (!Stall) begin
                        if (Halt) begin
                            state <= StDone;
                            Run   <= 1'b0;
                            Ack   <= 1'b1;
                        end else if (Branch && Take) begin
                            Prog_Ctr <= Target;
                        end else begin
                            Prog_Ctr <= Prog_Ctr + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    Run   <= 1'b0;
                    Ack   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_CYCLE_CNT_EN
    // Counts every RUN cycle (stalls and the halting cycle included), saturating.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Cycle_Count <= '0;
        end else if ((state == StIdle || state == StDone) && start) begin
            Cycle_Count <= '0;
        end else if (state == StRun && Cycle_Count != {CNT_W{1'b1}}) begin
            Cycle_Count <= Cycle_Count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a 10-bit PC instance and a 4-bit PC instance run in lockstep.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset, req, stall, halt, branch, take;
    logic [9:0] target;
    logic [3:0] target4;
    logic [9:0] pc;
    logic [3:0] pc4;
    logic       run, ack, run4, ack4;
`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] cnt;
    logic [15:0] cnt4;
`endif

    assign target4 = target[3:0];

    always #5 clk = ~clk;

    fetch_sequencer #(.PC_W(10), .START_ADDR(0), .CNT_W(16)) dut (
        .Clk(clk), .Reset(reset), .Req(req), .Stall(stall), .Halt(halt), .Branch(branch),
        .Take(take), .Target(target), .Prog_Ctr(pc), .Run(run), .Ack(ack)
`ifdef FETCH_CYCLE_CNT_EN
        , .Cycle_Count(cnt)
`endif
    );

    fetch_sequencer #(.PC_W(4), .START_ADDR(0), .CNT_W(16)) dut4 (
        .Clk(clk), .Reset(reset), .Req(req), .Stall(stall), .Halt(halt), .Branch(branch),
        .Take(take), .Target(target4), .Prog_Ctr(pc4), .Run(run4), .Ack(ack4)
`ifdef FETCH_CYCLE_CNT_EN
        , .Cycle_Count(cnt4)
`endif
    );

    typedef struct {
        logic [9:0]  pc;
        logic        run;
        logic        ack;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s step %0d actual %0h required %0h", name, step, act, exp_v);
        end
    endtask

    // Monitor: one expectation per clock, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc", int'(pc), int'(e.pc));
            chk("pc4", int'(pc4), int'(e.pc[3:0]));
            chk("run", int'(run), int'(e.run));
            chk("ack", int'(ack), int'(e.ack));
            chk("run4", int'(run4), int'(e.run));
            chk("ack4", int'(ack4), int'(e.ack));
`ifdef FETCH_CYCLE_CNT_EN
            chk("cnt", int'(cnt), int'(e.cnt));
            chk("cnt4", int'(cnt4), int'(e.cnt));
`endif
            step++;
        end
    end

    // Apply inputs for one clock and queue the hand-computed outputs after that edge.
    task automatic cyc(input int rst_v, input int req_v, input int stall_v, input int halt_v,
                       input int br_v, input int take_v, input int tgt_v,
                       input int epc, input int erun, input int eack, input int ecnt);
        exp_t e;
        reset  = (rst_v != 0);
        req    = (req_v != 0);
        stall  = (stall_v != 0);
        halt   = (halt_v != 0);
        branch = (br_v != 0);
        take   = (take_v != 0);
        target = 10'(tgt_v);
        @(posedge clk);
        #1;
        e.pc  = 10'(epc);
        e.run = (erun != 0);
        e.ack = (eack != 0);
        e.cnt = 16'(ecnt);
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog step %0d actual timeout required finish", step);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = 1'b0; stall = 1'b0; halt = 1'b0;
        branch = 1'b0; take = 1'b0; target = '0;
        //   rst req stl hlt br tk tgt     pc   run ack cnt
        cyc(1, 0, 0, 0, 0, 0, 0,      0,    0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0,      0,    0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0,      0,    0, 0, 0);
        // Start pulse, then sequential fetch
        cyc(0, 1, 0, 0, 0, 0, 0,      0,    1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0,      1,    1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0,      2,    1, 0, 2);
        cyc(0, 0, 0, 0, 0, 0, 0,      3,    1, 0, 3);
        cyc(0, 0, 0, 0, 0, 0, 0,      4,    1, 0, 4);
        cyc(0, 0, 0, 0, 0, 0, 0,      5,    1, 0, 5);
        // Branch taken / not taken at PC=5
        cyc(0, 0, 0, 0, 1, 1, 'h2A,   'h2A, 1, 0, 6);
        cyc(0, 0, 0, 0, 1, 1, 5,      5,    1, 0, 7);
        cyc(0, 0, 0, 0, 1, 0, 'h2A,   6,    1, 0, 8);
        cyc(0, 0, 0, 0, 0, 0, 0,      7,    1, 0, 9);
        // Halt beats branch; Req rising in RUN is ignored
        cyc(0, 1, 0, 1, 1, 1, 'h2A,   7,    0, 1, 10);
        cyc(0, 1, 0, 0, 0, 0, 0,      7,    0, 1, 10);
        cyc(0, 1, 0, 0, 0, 0, 0,      7,    0, 1, 10);
        cyc(0, 0, 0, 0, 0, 0, 0,      7,    0, 1, 10);
        cyc(0, 1, 0, 0, 0, 0, 0,      0,    1, 0, 0);
        // Wrap: 4-bit instance 14,15,0; 10-bit instance 0x3FF -> 0
        cyc(0, 0, 0, 0, 1, 1, 14,     14,   1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0,      15,   1, 0, 2);
        cyc(0, 0, 0, 0, 0, 0, 0,      16,   1, 0, 3);
        cyc(0, 0, 0, 0, 1, 1, 'h3FF,  'h3FF, 1, 0, 4);
        cyc(0, 0, 0, 0, 0, 0, 0,      0,    1, 0, 5);
        cyc(0, 0, 0, 0, 0, 0, 0,      1,    1, 0, 6);
        cyc(0, 0, 0, 0, 0, 0, 0,      2,    1, 0, 7);
        cyc(0, 0, 0, 0, 0, 0, 0,      3,    1, 0, 8);
        // Stall masks Halt and Branch
        cyc(0, 0, 1, 1, 0, 0, 0,      3,    1, 0, 9);
        cyc(0, 0, 1, 1, 1, 1, 'h2A,   3,    1, 0, 10);
        cyc(0, 0, 1, 1, 0, 0, 0,      3,    1, 0, 11);
        cyc(0, 0, 0, 0, 0, 0, 0,      4,    1, 0, 12);
        cyc(0, 0, 0, 0, 0, 0, 0,      5,    1, 0, 13);
        cyc(0, 0, 0, 0, 0, 0, 0,      6,    1, 0, 14);
        cyc(0, 0, 0, 0, 0, 0, 0,      7,    1, 0, 15);
        cyc(0, 0, 0, 0, 0, 0, 0,      8,    1, 0, 16);
        cyc(0, 0, 0, 0, 0, 0, 0,      9,    1, 0, 17);
        // Reset mid-program with Req held: restarts right after reset
        cyc(1, 1, 0, 0, 0, 0, 0,      0,    0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0,      0,    1, 0, 0);
        // Cycle count: 4 RUN cycles (one stalled) then Halt -> 5
        cyc(0, 1, 0, 0, 0, 0, 0,      1,    1, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 0,      1,    1, 0, 2);
        cyc(0, 1, 0, 0, 0, 0, 0,      2,    1, 0, 3);
        cyc(0, 1, 0, 0, 0, 0, 0,      3,    1, 0, 4);
        cyc(0, 1, 0, 1, 0, 0, 0,      3,    0, 1, 5);
        cyc(0, 0, 0, 0, 0, 0, 0,      3,    0, 1, 5);
        cyc(0, 0, 0, 0, 0, 0, 0,      3,    0, 1, 5);
        cyc(0, 1, 0, 0, 0, 0, 0,      0,    1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0,      0,    0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0,      0,    0, 1, 1);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain step %0d actual %0d pending required 0", step, q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and run-control stage directly upstream of the control decoder.
- Holds the PC that addresses instruction memory; the fetched instruction's opcode field feeds the decoder.
- Consumes the decoder's Branch and Halt outputs, plus the datapath's resolved branch condition, to pick the next PC.
- Implements the top-level Req/Ack start/done handshake.

Parameters:
- PC_W, 10, program counter width in bits.
- START_ADDR, 0, PC value loaded on every program start.
- CNT_W, 16, cycle counter width (used only with the optional feature).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  1  start request from the test harness; a start happens on a rising edge of Req.
- Stall  input  1  datapath hold; freezes the PC while asserted in RUN.
- Halt  input  1  decoder Halt for the instruction currently at Prog_Ctr.
- Branch  input  1  decoder Branch for the instruction currently at Prog_Ctr.
- Take  input  1  datapath-resolved branch condition (1 = taken); ignored unless Branch=1.
- Target  input  PC_W  branch target address supplied by the datapath.
- Prog_Ctr  output  PC_W  current instruction address.
- Run  output  1  high while executing; gates register-file and memory writes downstream.
- Ack  output  1  program done; high in DONE.
- Cycle_Count  output  CNT_W  executed-cycle count (only with FETCH_CYCLE_CNT_EN).

Behaviour:
- Reset (synchronous, active-high):
  - State=IDLE, Prog_Ctr=START_ADDR, Run=0, Ack=0, Req_q=0, Cycle_Count=0.
  - Reset dominates every other input, in any state and mid-program.
- Req_q: a registered copy of Req. start = Req & ~Req_q.
- IDLE:
  - Run=0, Ack=0.
  - On start: go to RUN and load Prog_Ctr=START_ADDR.
- RUN:
  - Run=1, Ack=0. One PC update per cycle, chosen by this priority:
    1. Stall=1: Prog_Ctr holds. Halt, Branch and Take are ignored.
    2. Halt=1: Prog_Ctr holds and the state goes to DONE next cycle. Halt beats Branch when both are high.
    3. Branch=1 and Take=1: Prog_Ctr <= Target.
    4. Otherwise: Prog_Ctr <= Prog_Ctr + 1, modulo 2^PC_W. The all-ones address wraps to 0 with no flag.
  - Branch=1 with Take=0 falls through to PC+1.
  - A start seen in RUN is ignored (no restart mid-program).
- DONE:
  - Run=0, Ack=1. Prog_Ctr holds the address of the HALT instruction.
  - On start: go to RUN, Prog_Ctr=START_ADDR, Ack drops in the same cycle RUN is entered.
  - With Req held high there is no restart; Req must fall and rise again.
- Outputs are all registered; there are no combinational paths from inputs to outputs.
  - Latency from a start edge to Run=1 is one clock.
  - The first instruction executes at START_ADDR in the first RUN cycle.
- Next-PC arithmetic is PC_W bits, unsigned. Target is used verbatim.
- Illegal state encoding recovers to IDLE on the next clock.

Optional Feature:
- Macro FETCH_CYCLE_CNT_EN.
- Defined:
  - Cycle_Count port exists.
  - Cleared to 0 on Reset and on every start.
  - Increments by 1 in each RUN cycle, including stalled cycles.
  - Saturates at 2^CNT_W-1.
  - Frozen in DONE and IDLE, so it reads the total program cycles while Ack=1.
- Not defined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then pulse Req for 1 cycle with Halt=Branch=0 → next cycle Run=1, Prog_Ctr=0; then Prog_Ctr goes 1, 2, 3 on successive cycles; Ack=0.
- In RUN at PC=5, drive Branch=1, Take=1, Target=0x2A → next Prog_Ctr=0x2A. Repeat with Take=0 → next Prog_Ctr=6.
- At PC=7, drive Halt=1 and Branch=1, Take=1 together → state DONE, Ack=1, Run=0, Prog_Ctr stays 7. Holding Req high causes no restart; drop Req, then raise it → Run=1, Prog_Ctr=0, Ack=0.
- With PC_W=4, run from PC=14 with no branch or halt → Prog_Ctr 15, then 0. Assert Stall for 3 cycles at PC=3, with Halt=1 during the stall → PC stays 3 and there is no DONE; release Stall → PC=4.
- Assert Reset at PC=9 mid-program while Req=1 → next cycle IDLE, Prog_Ctr=0, Run=0, Ack=0. Because Req_q clears on reset, the held-high Req counts as a rising edge: the first cycle after Reset deasserts, Req_q is still 0, a start is seen, and the state goes to RUN.
- FETCH_CYCLE_CNT_EN defined: start, 4 RUN cycles including 1 stalled, then Halt → in DONE Cycle_Count=5 (the Halt cycle counts) and stays 5; on restart it clears to 0.
